// File: rtl/shift_seq_ctrl.sv
// Command-driven sequencer for an 8-bit left-shift register: loads a value,
// steps it one bit per clock (logical or rotate), and returns the result.
module shift_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic             cmd_rot,
   input  logic             abort,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy,
   output logic [WIDTH-1:0] shift_out
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic             rot_q, rot_d;
   logic             accept;

   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] val,
                                                   input logic rot);
      logic [WIDTH-1:0] res;
      res = rot ? {val[WIDTH-2:0], val[WIDTH-1]} : {val[WIDTH-2:0], 1'b0};
      return res;
   endfunction

   // Abort and reset both close the accept window, so acceptance needs no further gating.
   assign cmd_ready = (state_q == IDLE) && !abort && rst;
   assign accept    = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         rot_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         rot_q   <= rot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (cmd_amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (cnt_q == AMT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (abort || res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The shift still lands on an aborting edge; abort only redirects the FSM,
   // leaving the partial value visible on shift_out.
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      rot_d   = rot_q;
      if (state_q == IDLE) begin
         if (accept) begin
            shreg_d = cmd_data;
            cnt_d   = cmd_amt;
            rot_d   = cmd_rot;
         end
      end else if (state_q == SHIFT) begin
         shreg_d = shift_step(shreg_q, rot_q);
         cnt_d   = cnt_q - AMT_W'(1);
      end
   end

   always_comb begin
      busy      = (state_q != IDLE);
      res_valid = (state_q == DONE);
      res_data  = (state_q == DONE) ? shreg_q : '0;
      shift_out = shreg_q;
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: reset, logical/rotate shifts, amount
// boundaries, result backpressure, abort and mid-operation reset.
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_data = 8'h00;
   logic [3:0] cmd_amt = 4'd0;
   logic       cmd_rot = 1'b0;
   logic       abort = 1'b0;
   logic       res_valid;
   logic       res_ready = 1'b1;
   logic [7:0] res_data;
   logic       busy;
   logic [7:0] shift_out;

   int n_cmp = 0;
   int n_err = 0;

   shift_seq_ctrl #(.WIDTH(8), .AMT_W(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_data(cmd_data), .cmd_amt(cmd_amt), .cmd_rot(cmd_rot),
      .abort(abort),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .shift_out(shift_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents a command and advances through its accept edge.
   task automatic send(input logic [7:0] d, input logic [3:0] a, input logic r);
      cmd_data  = d;
      cmd_amt   = a;
      cmd_rot   = r;
      cmd_valid = 1'b1;
      chk("send_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      // 1. Reset with cmd_valid high
      cmd_valid = 1'b1;
      cmd_data  = 8'h3C;
      cmd_amt   = 4'd2;
      #1 rst = 1'b0;
      tick();
      tick();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_shift_out", shift_out, 8'h00);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_data", res_data, 8'h00);
      cmd_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rel_cmd_ready", cmd_ready, 1);
      tick();
      chk("rel_busy", busy, 0);
      chk("rel_shift_out", shift_out, 8'h00);

      // 2. Logical shift 0x81 by 3
      res_ready = 1'b1;
      send(8'h81, 4'd3, 1'b0);
      chk("lsl_s0", shift_out, 8'h81);
      chk("lsl_busy", busy, 1);
      chk("lsl_ready_busy", cmd_ready, 0);
      tick();
      chk("lsl_s1", shift_out, 8'h02);
      chk("lsl_nores1", res_valid, 0);
      tick();
      chk("lsl_s2", shift_out, 8'h04);
      chk("lsl_nores2", res_valid, 0);
      tick();
      chk("lsl_s3", shift_out, 8'h08);
      chk("lsl_res_valid", res_valid, 1);
      chk("lsl_res_data", res_data, 8'h08);
      tick();
      chk("lsl_idle_ready", cmd_ready, 1);
      chk("lsl_idle_res", res_valid, 0);

      // 3. Rotate 0x81 by 3
      send(8'h81, 4'd3, 1'b1);
      chk("rol_s0", shift_out, 8'h81);
      tick();
      chk("rol_s1", shift_out, 8'h03);
      tick();
      chk("rol_s2", shift_out, 8'h06);
      tick();
      chk("rol_s3", shift_out, 8'h0C);
      chk("rol_res_valid", res_valid, 1);
      chk("rol_res_data", res_data, 8'h0C);
      tick();

      // 4. Boundaries
      send(8'hA5, 4'd0, 1'b0);
      chk("amt0_res_valid", res_valid, 1);
      chk("amt0_res_data", res_data, 8'hA5);
      tick();
      chk("amt0_idle", busy, 0);

      send(8'hFF, 4'd9, 1'b0);
      for (int i = 0; i < 8; i++) tick();
      chk("lsl9_not_yet", res_valid, 0);
      tick();
      chk("lsl9_res_valid", res_valid, 1);
      chk("lsl9_res_data", res_data, 8'h00);
      tick();

      send(8'h81, 4'd9, 1'b1);
      for (int i = 0; i < 9; i++) tick();
      chk("rol9_res_valid", res_valid, 1);
      chk("rol9_res_data", res_data, 8'h03);
      tick();

      // 5. Backpressure with a competing command during the stall
      res_ready = 1'b0;
      send(8'h01, 4'd2, 1'b0);
      tick();
      tick();
      chk("bp_res_valid0", res_valid, 1);
      cmd_data  = 8'h55;
      cmd_amt   = 4'd1;
      cmd_rot   = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_res_valid", res_valid, 1);
         chk("bp_res_data", res_data, 8'h04);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_shift_out", shift_out, 8'h04);
      end
      res_ready = 1'b1;
      tick();
      chk("bp_idle_busy", busy, 0);
      chk("bp_idle_res", res_valid, 0);
      chk("bp_idle_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("bp_accept55", shift_out, 8'h55);
      chk("bp_busy55", busy, 1);
      tick();
      chk("bp_res55_valid", res_valid, 1);
      chk("bp_res55_data", res_data, 8'hAA);
      tick();

      // 6a. Abort sampled on the third SHIFT edge
      send(8'hFF, 4'd6, 1'b0);
      tick();
      chk("ab_s1", shift_out, 8'hFE);
      tick();
      chk("ab_s2", shift_out, 8'hFC);
      abort = 1'b1;
      #1;
      chk("ab_busy_ready", cmd_ready, 0);
      tick();
      chk("ab_shift_out", shift_out, 8'hF8);
      chk("ab_busy", busy, 0);
      chk("ab_ready_abort_hi", cmd_ready, 0);
      abort = 1'b0;
      #1;
      chk("ab_ready", cmd_ready, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ab_no_res", res_valid, 0);
      end
      chk("ab_hold", shift_out, 8'hF8);

      // 6b. Asynchronous reset mid-SHIFT
      send(8'hFF, 4'd6, 1'b0);
      tick();
      tick();
      chk("rs_pre", shift_out, 8'hFC);
      #2 rst = 1'b0;
      #1;
      chk("rs_shift_out", shift_out, 8'h00);
      chk("rs_busy", busy, 0);
      chk("rs_ready", cmd_ready, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rs_no_res", res_valid, 0);
         chk("rs_idle", busy, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command-driven sequencer for the 8-bit left-shift datapath. It accepts a load value, a shift amount and a mode over a valid/ready handshake, then steps the shift register one bit per clock. It returns the result over a second valid/ready handshake. It sits between a requesting controller and the shift datapath, and exposes the live register for waveform and debug visibility.

Parameters:
WIDTH, 8, shift register width in bits
AMT_W, 4, width of the shift-amount field; amounts 0..2^AMT_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (low = reset asserted)
cmd_valid  input  1  command presented
cmd_ready  output  1  block can accept a command
cmd_data  input  WIDTH  value loaded into the shift register
cmd_amt  input  AMT_W  number of single-bit shift steps
cmd_rot  input  1  1 = rotate left (MSB wraps to LSB); 0 = logical shift left (LSB filled with 0)
abort  input  1  synchronous cancel of the current operation
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  final register value, valid while res_valid
busy  output  1  high when state != IDLE
shift_out  output  WIDTH  live shift register contents

Behaviour:
- Reset (rst low, async):
  - state = IDLE; shift register, step counter and latched mode cleared to 0.
  - res_valid = 0, busy = 0, shift_out = 0, res_data = 0.
  - cmd_ready forced to 0 while rst is low.
- FSM states: IDLE, SHIFT, DONE.
- cmd_ready = (state == IDLE) && !abort && rst. Combinational; no other inputs feed it.
- IDLE:
  - On cmd_valid && cmd_ready at edge k: reg <= cmd_data, cnt <= cmd_amt, mode <= cmd_rot.
  - Next state is DONE if cmd_amt == 0, otherwise SHIFT.
  - cmd_data, cmd_amt and cmd_rot are sampled only on the accept edge.
- SHIFT:
  - Each edge: reg <= rot ? {reg[WIDTH-2:0], reg[WIDTH-1]} : {reg[WIDTH-2:0], 1'b0}; cnt <= cnt - 1.
  - When cnt == 1 at the edge, next state is DONE.
  - The amount is not clamped:
    - Logical shift with amt >= WIDTH yields 0.
    - Rotate yields a rotation of amt mod WIDTH.
- DONE:
  - res_valid = 1; res_data = reg, held stable.
  - On res_ready, next state is IDLE. res_valid stays high until the handshake.
- Latency:
  - res_valid rises at accept edge k + N (N = cmd_amt); for N = 0 it rises on the accept edge itself.
  - Minimum command period is N + 2 cycles with res_ready tied high.
- shift_out:
  - Always equals reg; it updates on the load edge and on every shift edge.
  - Holds its value in DONE and IDLE.
- abort (sampled on clock edge, highest priority after reset):
  - IDLE: suppresses acceptance (cmd_ready low).
  - SHIFT: next state is IDLE; reg keeps its partial value; no result is produced.
  - DONE: next state is IDLE and the result is dropped. If res_ready is high on the same edge, the transfer counts as completed.
- cmd_valid while busy: ignored, no side effects; the requester must hold it until cmd_ready.
- rst asserted mid-operation: immediate clear to the reset values above. No result is emitted after rst releases.
- cnt width is AMT_W; it never wraps below 0 because SHIFT is only entered with cnt >= 1.

Test Plan:
1. Reset:
   - Stimulus: hold rst low 2 cycles with cmd_valid high.
   - Required: cmd_ready = 0, shift_out = 0x00, res_valid = 0, busy = 0.
   - After release: cmd_ready = 1 and no command has been accepted.
2. Logical shift:
   - Stimulus: cmd_data = 0x81, amt = 3, rot = 0, res_ready = 1.
   - Required: shift_out sequence 0x81, 0x02, 0x04, 0x08; res_valid high 3 edges after accept with res_data = 0x08; cmd_ready high one cycle later.
3. Rotate:
   - Stimulus: 0x81, amt = 3, rot = 1.
   - Required: shift_out sequence 0x81, 0x03, 0x06, 0x0C; res_data = 0x0C.
4. Boundaries:
   - amt = 0, data 0xA5: res_valid on the accept edge with res_data = 0xA5.
   - Logical, amt = 9, data 0xFF: res_data = 0x00.
   - Rotate, amt = 9, data 0x81: res_data = 0x03.
5. Backpressure:
   - Stimulus: amt = 2 on 0x01; hold res_ready low 5 cycles; pulse cmd_valid with 0x55 during the stall.
   - Required: res_data stays 0x04, res_valid stays 1, cmd_ready stays 0 and 0x55 is not accepted. After res_ready goes high: IDLE, then 0x55 is accepted.
6. Abort and reset mid-operation:
   - Abort: 0xFF, amt = 6, logical; abort on the third SHIFT edge. Required: shift_out = 0xF8, res_valid never rises, cmd_ready = 1 the next cycle.
   - Reset: repeat the command and drop rst between clock edges mid-SHIFT. Required: shift_out = 0x00 immediately; no result after release.
